// File: rtl/wb_spi_sched.sv
// Wishbone sequencer: forwards CPU SPI accesses and replays a command table as atomic refresh frames.
// Local regs ack next cycle; pass-through acks one cycle after m_ack_i and stalls while a frame runs.
module wb_spi_sched #(
  parameter int N_CMDS   = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, CPU_X, SEQ_ISSUE, SEQ_WAIT} state_t;
  localparam logic [3:0] CNT_MAX = 4'(N_CMDS);

  logic                en_q;
  logic [3:0]          count_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] timer_q;
  logic                pending_q;
  logic                overrun_q;
  logic [1:0]          meta_len [8];
  logic [2:0]          meta_cs  [8];
  logic [31:0]         data_q   [8];

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, fcnt_q, fcnt_d;
  logic        drop_q, drop_d;
  logic [31:0] m_adr_d, m_dat_d, s_dat_d;
  logic [3:0]  m_sel_d;
  logic        m_we_d, m_stb_d, m_cyc_d, s_ack_d, busy_d;
  logic        clr_pending;

  logic [7:0]  a;
  logic        loc_req, loc_wr, cpu_req;
  logic [2:0]  tbl_idx;
  logic        tbl_hit, meta_sel, data_sel;
  logic        expire, pend_now;
  logic [3:0]  count_wr;
  logic [31:0] rd_dat;
  logic [2:0]  e;
  logic [1:0]  cur_len;
  logic        unused_ok;

  assign a         = s_adr_i[7:0];
  assign unused_ok = ^s_adr_i[31:8];
  assign loc_req   = s_stb_i & s_cyc_i & a[7] & ~s_ack_o;
  assign loc_wr    = loc_req & s_we_i;
  assign cpu_req   = s_stb_i & s_cyc_i & ~a[7] & ~s_ack_o;
  assign tbl_idx   = a[4:2];
  assign tbl_hit   = ({1'b0, tbl_idx} < CNT_MAX) && (a[1:0] == 2'b00);
  assign meta_sel  = (a[7:5] == 3'b101) & tbl_hit;
  assign data_sel  = (a[7:5] == 3'b110) & tbl_hit;
  assign expire    = en_q & (timer_q == '0);
  // An expiry in the same cycle as a CPU request must still win the tie.
  assign pend_now  = pending_q | expire;
  assign count_wr  = (s_dat_i[11:8] > CNT_MAX) ? CNT_MAX : s_dat_i[11:8];
  assign e         = idx_q[2:0];
  assign cur_len   = meta_len[e];

  always_comb begin
    rd_dat = '0;
    if (a == 8'h80)      rd_dat = {20'd0, count_q, 7'd0, en_q};
    else if (a == 8'h84) rd_dat = 32'(period_q);
    else if (a == 8'h88) rd_dat = {29'd0, overrun_q, busy_o, pending_q};
    else if (meta_sel)   rd_dat = {25'd0, meta_cs[tbl_idx], 2'd0, meta_len[tbl_idx]};
    else if (data_sel)   rd_dat = data_q[tbl_idx];
  end

  always_ff @(posedge clk) begin
    if (loc_wr && meta_sel) begin
      meta_len[tbl_idx] <= s_dat_i[1:0];
      meta_cs[tbl_idx]  <= s_dat_i[6:4];
    end
    if (loc_wr && data_sel) data_q[tbl_idx] <= s_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      count_q   <= '0;
      period_q  <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (loc_wr && a == 8'h80) begin
        en_q    <= s_dat_i[0];
        count_q <= count_wr;
      end
      if (loc_wr && a == 8'h84) period_q <= s_dat_i[PERIOD_W-1:0];

      if (!en_q || expire) timer_q <= period_q;
      else                 timer_q <= timer_q - PERIOD_W'(1);

      if (!en_q || clr_pending) pending_q <= 1'b0;
      else if (expire)          pending_q <= 1'b1;

      if (expire && (pending_q || busy_o))           overrun_q <= 1'b1;
      else if (loc_wr && a == 8'h88 && s_dat_i[2])   overrun_q <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    drop_d      = drop_q;
    m_adr_d     = m_adr_o;
    m_dat_d     = m_dat_o;
    m_we_d      = m_we_o;
    m_sel_d     = m_sel_o;
    m_stb_d     = m_stb_o;
    m_cyc_d     = m_cyc_o;
    s_ack_d     = 1'b0;
    s_dat_d     = s_dat_o;
    busy_d      = busy_o;
    clr_pending = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_now && count_q != 4'd0) begin
          state_d     = SEQ_ISSUE;
          idx_d       = 4'd0;
          fcnt_d      = count_q;
          busy_d      = 1'b1;
          clr_pending = 1'b1;
        end else if (pend_now) begin
          clr_pending = 1'b1;
        end else if (cpu_req) begin
          state_d = CPU_X;
          drop_d  = 1'b0;
          m_adr_d = {25'd0, s_adr_i[6:4], 4'd0};
          m_dat_d = s_dat_i;
          m_we_d  = s_we_i;
          m_sel_d = s_sel_i;
          m_stb_d = 1'b1;
          m_cyc_d = 1'b1;
        end
      end
      CPU_X: begin
        // An abandoned CPU cycle still runs to completion on the SPI side.
        drop_d = drop_q | ~s_cyc_i;
        if (m_ack_i) begin
          m_stb_d = 1'b0;
          m_cyc_d = 1'b0;
          state_d = IDLE;
          if (!drop_d) begin
            s_ack_d = 1'b1;
            s_dat_d = m_dat_i;
          end
        end
      end
      SEQ_ISSUE: begin
        if (cur_len == 2'd3) begin
          idx_d = idx_q + 4'd1;
          if (idx_q + 4'd1 == fcnt_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          m_we_d  = 1'b1;
          m_sel_d = (cur_len == 2'd0) ? 4'b0001 : (cur_len == 2'd1) ? 4'b0011 : 4'b1111;
          m_dat_d = data_q[e];
          m_adr_d = {25'd0, meta_cs[e], 4'd0};
          m_stb_d = 1'b1;
          m_cyc_d = 1'b1;
          state_d = SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        if (m_ack_i) begin
          m_stb_d = 1'b0;
          m_cyc_d = 1'b0;
          idx_d   = idx_q + 4'd1;
          if (idx_q + 4'd1 == fcnt_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = SEQ_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (loc_req) begin
      s_ack_d = 1'b1;
      s_dat_d = rd_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fcnt_q  <= '0;
      drop_q  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_stb_o <= 1'b0;
      m_cyc_o <= 1'b0;
      s_ack_o <= 1'b0;
      s_dat_o <= '0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      drop_q  <= drop_d;
      m_adr_o <= m_adr_d;
      m_dat_o <= m_dat_d;
      m_we_o  <= m_we_d;
      m_sel_o <= m_sel_d;
      m_stb_o <= m_stb_d;
      m_cyc_o <= m_cyc_d;
      s_ack_o <= s_ack_d;
      s_dat_o <= s_dat_d;
      busy_o  <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_spi_sched.sv
// Directed bench for wb_spi_sched with a small wb_spi slave model that logs every SPI cycle.
module tb_wb_spi_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_adr_i, s_dat_i, s_dat_o, m_adr_o, m_dat_o, m_dat_i;
  logic        s_we_i, s_stb_i, s_cyc_i, s_ack_o, m_we_o, m_stb_o, m_cyc_o, m_ack_i, busy_o;
  logic [3:0]  s_sel_i, m_sel_o;

  int vecs = 0;
  int errs = 0;
  int ncyc = 0;
  int spi_lat = 1;
  int wcnt = 0;
  int lg_n = 0;
  logic [31:0] lg_adr [128];
  logic [31:0] lg_dat [128];
  logic [3:0]  lg_sel [128];
  logic        lg_we  [128];
  logic        lg_busy[128];
  int          lg_cyc [128];

  wb_spi_sched #(.N_CMDS(8), .PERIOD_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  // wb_spi stand-in: acks after spi_lat wait cycles and records the transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack_i = 1'b0;
      wcnt = 0;
    end else if (m_ack_i) begin
      m_ack_i = 1'b0;
    end else if (m_stb_o && m_cyc_o) begin
      if (wcnt >= spi_lat) begin
        m_ack_i = 1'b1;
        m_dat_i = 32'hD000_0000 + lg_n;
        if (lg_n < 128) begin
          lg_adr[lg_n] = m_adr_o; lg_dat[lg_n] = m_dat_o; lg_sel[lg_n] = m_sel_o;
          lg_we[lg_n] = m_we_o; lg_busy[lg_n] = busy_o; lg_cyc[lg_n] = ncyc;
        end
        lg_n++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  task automatic cpu_acc(input logic [7:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel,
                         output logic [31:0] rd, output int ack_cyc);
    logic ok;
    ok = 1'b0; rd = '0; ack_cyc = 0;
    s_adr_i = {24'd0, a}; s_dat_i = d; s_we_i = we; s_sel_i = sel; s_stb_i = 1'b1; s_cyc_i = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (s_ack_o) begin ok = 1'b1; rd = s_dat_o; ack_cyc = ncyc; break; end
    end
    s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
    vecs++;
    if (!ok) begin errs++; $display("FAIL ack_timeout adr=%h got no s_ack_o, need one", a); end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r; int c;
    cpu_acc(a, d, 1'b1, 4'hF, r, c);
  endtask

  task automatic rdreg(input logic [7:0] a, output logic [31:0] r);
    int c;
    cpu_acc(a, 32'h0, 1'b0, 4'hF, r, c);
  endtask

  task automatic wait_busy(input logic lvl, input int maxc);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (busy_o === lvl) begin ok = 1'b1; break; end
    end
    vecs++;
    if (!ok) begin errs++; $display("FAIL busy_wait got busy_o=%b, need %b", busy_o, lvl); end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst_n = 1'b0;
    s_adr_i = '0; s_dat_i = '0; s_we_i = 0; s_sel_i = '0; s_stb_i = 0; s_cyc_i = 0;
    m_ack_i = 0; m_dat_i = '0;
    repeat (3) @(negedge clk);
    vecs++; if ({s_ack_o, s_dat_o, m_stb_o, m_cyc_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, busy_o} !== '0) begin
      errs++; $display("FAIL reset_outputs got ack=%b dat=%h stb=%b cyc=%b busy=%b, need all 0", s_ack_o, s_dat_o, m_stb_o, m_cyc_o, busy_o); end
    rst_n = 1'b1;
    @(negedge clk);
    rdreg(8'h80, r); vecs++; if (r !== 32'h0) begin errs++; $display("FAIL reset_ctrl got %h need 0", r); end
    rdreg(8'h84, r); vecs++; if (r !== 32'h0) begin errs++; $display("FAIL reset_period got %h need 0", r); end
    rdreg(8'h88, r); vecs++; if (r !== 32'h0) begin errs++; $display("FAIL reset_status got %h need 0", r); end
  endtask

  task automatic test_passthrough;
    logic [31:0] r; int c, n0;
    spi_lat = 2; n0 = lg_n;
    cpu_acc(8'h20, 32'hA5, 1'b1, 4'b0001, r, c);
    vecs++; if (lg_n !== n0 + 1) begin errs++; $display("FAIL pt_count got %0d need %0d", lg_n - n0, 1); end
    vecs++; if (lg_sel[n0] !== 4'b0001) begin errs++; $display("FAIL pt_sel got %b need 0001", lg_sel[n0]); end
    vecs++; if (lg_adr[n0] !== 32'h20) begin errs++; $display("FAIL pt_adr got %h need 00000020", lg_adr[n0]); end
    vecs++; if (lg_dat[n0] !== 32'hA5) begin errs++; $display("FAIL pt_dat got %h need 000000a5", lg_dat[n0]); end
    vecs++; if (lg_we[n0] !== 1'b1) begin errs++; $display("FAIL pt_we got %b need 1", lg_we[n0]); end
    vecs++; if (c - lg_cyc[n0] !== 1) begin errs++; $display("FAIL pt_ack_lat got %0d need 1", c - lg_cyc[n0]); end
    vecs++; if (m_cyc_o !== 1'b0) begin errs++; $display("FAIL pt_cyc_drop got %b need 0", m_cyc_o); end
    @(negedge clk);
    vecs++; if (s_ack_o !== 1'b0) begin errs++; $display("FAIL pt_ack_pulse got %b need 0", s_ack_o); end
    cpu_acc(8'h10, 32'h0, 1'b0, 4'hF, r, c);
    vecs++; if (r !== 32'hD000_0000 + n0 + 1) begin errs++; $display("FAIL pt_rdata got %h need %h", r, 32'hD000_0000 + n0 + 1); end
    vecs++; if (lg_adr[n0+1] !== 32'h10 || lg_we[n0+1] !== 1'b0) begin
      errs++; $display("FAIL pt_rd_cycle got adr=%h we=%b need 00000010/0", lg_adr[n0+1], lg_we[n0+1]); end
    spi_lat = 1;
  endtask

  task automatic test_regs;
    logic [31:0] r;
    wr(8'h80, 32'hF00); rdreg(8'h80, r);
    vecs++; if (r !== 32'h800) begin errs++; $display("FAIL count_clamp got %h need 00000800", r); end
    wr(8'h9C, 32'h123); rdreg(8'h9C, r);
    vecs++; if (r !== 32'h0) begin errs++; $display("FAIL unmapped got %h need 0", r); end
    wr(8'hA4, 32'h37); rdreg(8'hA4, r);
    vecs++; if (r !== 32'h33) begin errs++; $display("FAIL meta_rb got %h need 00000033", r); end
    wr(8'hC4, 32'hCAFE_F00D); rdreg(8'hC4, r);
    vecs++; if (r !== 32'hCAFE_F00D) begin errs++; $display("FAIL data_rb got %h need cafef00d", r); end
    wr(8'h80, 32'h0);
  endtask

  task automatic test_frame;
    logic [31:0] r; int n0; logic ok;
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    logic [3:0]  es [3];
    ea = '{32'h10, 32'h20, 32'h30};
    ed = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    es = '{4'b0001, 4'b0011, 4'b1111};
    wr(8'hA0, 32'h10); wr(8'hA4, 32'h21); wr(8'hA8, 32'h32);
    wr(8'hC0, ed[0]); wr(8'hC4, ed[1]); wr(8'hC8, ed[2]);
    wr(8'h84, 32'd1000);
    n0 = lg_n;
    wr(8'h80, 32'h301);
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (lg_n >= n0 + 6) begin ok = 1'b1; break; end
    end
    wr(8'h80, 32'h300);
    vecs++; if (!ok) begin errs++; $display("FAIL frame_timeout got %0d cycles need 6", lg_n - n0); end
    for (int j = 0; j < 6; j++) begin
      vecs++; if (lg_adr[n0+j] !== ea[j%3]) begin errs++; $display("FAIL frame_adr[%0d] got %h need %h", j, lg_adr[n0+j], ea[j%3]); end
      vecs++; if (lg_dat[n0+j] !== ed[j%3]) begin errs++; $display("FAIL frame_dat[%0d] got %h need %h", j, lg_dat[n0+j], ed[j%3]); end
      vecs++; if (lg_sel[n0+j] !== es[j%3]) begin errs++; $display("FAIL frame_sel[%0d] got %b need %b", j, lg_sel[n0+j], es[j%3]); end
      vecs++; if (lg_busy[n0+j] !== 1'b1 || lg_we[n0+j] !== 1'b1) begin
        errs++; $display("FAIL frame_busy_we[%0d] got %b/%b need 1/1", j, lg_busy[n0+j], lg_we[n0+j]); end
    end
    vecs++; if (lg_cyc[n0+3] - lg_cyc[n0] !== 1001) begin errs++; $display("FAIL frame_period got %0d need 1001", lg_cyc[n0+3] - lg_cyc[n0]); end
    rdreg(8'h88, r);
    vecs++; if (r !== 32'h0) begin errs++; $display("FAIL frame_status got %h need 0", r); end
  endtask

  task automatic test_tie;
    logic [31:0] r; int c, n0;
    wr(8'hA0, 32'h50); wr(8'hC0, 32'h77);
    wr(8'h84, 32'd20); wr(8'h80, 32'h100);
    n0 = lg_n;
    wr(8'h80, 32'h101);
    repeat (20) @(negedge clk);
    cpu_acc(8'h60, 32'hBEEF, 1'b1, 4'hF, r, c);
    vecs++; if (lg_n !== n0 + 2) begin errs++; $display("FAIL tie_count got %0d need 2", lg_n - n0); end
    vecs++; if (lg_adr[n0] !== 32'h50 || lg_dat[n0] !== 32'h77) begin
      errs++; $display("FAIL tie_frame_first got adr=%h dat=%h need 00000050/00000077", lg_adr[n0], lg_dat[n0]); end
    vecs++; if (lg_adr[n0+1] !== 32'h60 || lg_dat[n0+1] !== 32'hBEEF) begin
      errs++; $display("FAIL tie_cpu_second got adr=%h dat=%h need 00000060/0000beef", lg_adr[n0+1], lg_dat[n0+1]); end
    wr(8'h80, 32'h100);
    wait_busy(1'b0, 100);
  endtask

  task automatic test_overrun;
    logic [31:0] r;
    spi_lat = 15;
    wr(8'hA0, 32'h12); wr(8'h84, 32'd10); wr(8'h80, 32'h101);
    wait_busy(1'b1, 100);
    wait_busy(1'b0, 100);
    rdreg(8'h88, r);
    vecs++; if (r[2] !== 1'b1) begin errs++; $display("FAIL overrun_set got %b need 1", r[2]); end
    wr(8'h80, 32'h100);
    wait_busy(1'b0, 200);
    wr(8'h88, 32'h4); rdreg(8'h88, r);
    vecs++; if (r !== 32'h0) begin errs++; $display("FAIL overrun_clear got %h need 0", r); end
    spi_lat = 1;
  endtask

  task automatic test_skip;
    int n0;
    wr(8'hA0, 32'h10); wr(8'hA4, 32'h23); wr(8'hA8, 32'h32);
    wr(8'hC0, 32'hA1); wr(8'hC8, 32'hA3);
    wr(8'h84, 32'd50);
    n0 = lg_n;
    wr(8'h80, 32'h301);
    wait_busy(1'b1, 200);
    wait_busy(1'b0, 200);
    wr(8'h80, 32'h300);
    vecs++; if (lg_n !== n0 + 2) begin errs++; $display("FAIL skip_count got %0d need 2", lg_n - n0); end
    vecs++; if (lg_adr[n0] !== 32'h10 || lg_dat[n0] !== 32'hA1) begin
      errs++; $display("FAIL skip_e0 got adr=%h dat=%h need 00000010/000000a1", lg_adr[n0], lg_dat[n0]); end
    vecs++; if (lg_adr[n0+1] !== 32'h30 || lg_dat[n0+1] !== 32'hA3 || lg_sel[n0+1] !== 4'hF) begin
      errs++; $display("FAIL skip_e2 got adr=%h dat=%h sel=%b need 00000030/000000a3/1111", lg_adr[n0+1], lg_dat[n0+1], lg_sel[n0+1]); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] r; int n0; logic ok;
    spi_lat = 30;
    wr(8'hA0, 32'h12); wr(8'h80, 32'h100); wr(8'h84, 32'd5); wr(8'h80, 32'h101);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_stb_o) begin ok = 1'b1; break; end
    end
    vecs++; if (!ok) begin errs++; $display("FAIL rst_mid_start got m_stb_o=%b need 1", m_stb_o); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if ({m_stb_o, m_cyc_o, busy_o} !== 3'b000) begin
      errs++; $display("FAIL rst_mid_ctl got stb/cyc/busy=%b%b%b need 000", m_stb_o, m_cyc_o, busy_o); end
    vecs++; if ({m_adr_o, m_dat_o, m_sel_o, m_we_o, s_ack_o, s_dat_o} !== '0) begin
      errs++; $display("FAIL rst_mid_data got adr=%h dat=%h sel=%b need 0", m_adr_o, m_dat_o, m_sel_o); end
    @(negedge clk);
    rst_n = 1'b1;
    spi_lat = 1;
    n0 = lg_n;
    repeat (50) @(negedge clk);
    vecs++; if (lg_n !== n0 || busy_o !== 1'b0) begin
      errs++; $display("FAIL rst_quiet got %0d cycles busy=%b need 0/0", lg_n - n0, busy_o); end
    rdreg(8'h80, r);
    vecs++; if (r !== 32'h0) begin errs++; $display("FAIL rst_ctrl got %h need 0", r); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_regs();
    test_frame();
    test_tie();
    test_overrun();
    test_skip();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
